// File: rtl/noc_rsp_arb.sv
// Round-robin packet arbiter: grants one response source per packet and
// serializes its bytes onto the outbound NOC byte link.
module noc_rsp_arb #(
    parameter int NREQ   = 4,
    parameter int MAXLEN = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   pop,
    output logic [NREQ-1:0]   gnt,
    output logic              noc_from_dev_ctl,
    output logic [7:0]        noc_from_dev_data,
    output logic              busy,
    output logic              err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            first_q, first_d;
    logic            ctl_q, ctl_d;
    logic [7:0]      data_q, data_d;
    logic            err_q, err_d;

    logic [IW-1:0]   win_idx;
    logic            win_vld;
    logic [IW-1:0]   g_next;
    logic            g_req;
    logic            g_last;
    logic [7:0]      g_data;

    // First requester at or after ptr, wrapping around
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_vld && req[(int'(ptr_q) + k) % NREQ]) begin
                win_vld = 1'b1;
                win_idx = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign g_next = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
    assign g_req  = req[gidx_q];
    assign g_last = req_last[gidx_q];
    assign g_data = req_data[int'(gidx_q) * 8 +: 8];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        ctl_d   = ctl_q;
        data_d  = data_q;
        err_d   = err_q;
        pop     = '0;
        unique case (state_q)
            IDLE: begin
                ctl_d  = 1'b1;
                data_d = 8'h00;
                if (win_vld) begin
                    state_d        = XFER;
                    gidx_d         = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    cnt_d          = 8'd0;
                    first_d        = 1'b1;
                end
            end
            XFER: begin
                if (!g_req) begin
                    // Source vanished mid-packet: close the link out cleanly
                    ctl_d   = 1'b1;
                    data_d  = 8'h00;
                    state_d = IDLE;
                    gnt_d   = '0;
                    err_d   = 1'b1;
                    ptr_d   = g_next;
                end else begin
                    pop     = gnt_q;
                    data_d  = g_data;
                    ctl_d   = first_q;
                    first_d = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                    if (g_last || cnt_q == 8'(MAXLEN - 1)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = g_next;
                        if (!g_last) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            gnt_q   <= '0;
            cnt_q   <= 8'd0;
            first_q <= 1'b0;
            ctl_q   <= 1'b1;
            data_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            ctl_q   <= ctl_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign gnt               = gnt_q;
    assign noc_from_dev_ctl  = ctl_q;
    assign noc_from_dev_data = data_q;
    assign busy              = (state_q == XFER);
    assign err               = err_q;

endmodule

// File: tb/tb_noc_rsp_arb.sv
// Directed bench for noc_rsp_arb: two instances, default MAXLEN and MAXLEN=8.
module tb_noc_rsp_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req, req_last, pop, gnt;
    logic [31:0] req_data;
    logic        ctl, busy, err;
    logic [7:0]  data;

    logic [3:0]  breq, blast, bpop, bgnt;
    logic [31:0] bdata_in;
    logic        bctl, bbusy, berr;
    logic [7:0]  bdata;

    noc_rsp_arb #(.NREQ(4), .MAXLEN(255)) dut_a (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .req_last(req_last), .pop(pop), .gnt(gnt),
        .noc_from_dev_ctl(ctl), .noc_from_dev_data(data),
        .busy(busy), .err(err)
    );

    noc_rsp_arb #(.NREQ(4), .MAXLEN(8)) dut_b (
        .clk(clk), .rst(rst), .req(breq), .req_data(bdata_in),
        .req_last(blast), .pop(bpop), .gnt(bgnt),
        .noc_from_dev_ctl(bctl), .noc_from_dev_data(bdata),
        .busy(bbusy), .err(berr)
    );

    int total = 0;
    int bad = 0;

    logic [7:0] mem [4][256];
    int len [4];
    int pos [4];
    int pkts [4];
    int drop_at [4];
    int b_pos;
    bit b_on, b3_on;

    logic [3:0] s_pop, s_gnt, s_bpop, s_bgnt;
    logic       s_ctl, s_busy, s_err, s_bctl, s_berr;
    logic [7:0] s_data, s_bdata;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i] = (pkts[i] > 0) && (pos[i] != drop_at[i]);
            req_data[8*i +: 8] = mem[i][pos[i]];
            req_last[i] = (pos[i] == len[i] - 1);
        end
        breq = {b3_on, b_on, 2'b00};
        bdata_in = {8'hD3, 8'(8'h30 + b_pos), 16'h0000};
        blast = 4'b1000;
    endtask

    // Sample mid-cycle, then let registered sources advance after the edge
    task automatic run_cycle();
        @(negedge clk);
        s_pop = pop; s_gnt = gnt; s_ctl = ctl; s_data = data;
        s_busy = busy; s_err = err;
        s_bpop = bpop; s_bgnt = bgnt; s_bctl = bctl; s_bdata = bdata;
        s_berr = berr;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (s_pop[i]) begin
                pos[i]++;
                if (pos[i] == len[i]) begin
                    pos[i] = 0;
                    pkts[i]--;
                end
            end
        end
        if (s_bpop[2]) b_pos++;
        if (s_bpop[3]) b3_on = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pos[i] = 0; pkts[i] = 0; drop_at[i] = -1; len[i] = 1;
        end
        b_pos = 0; b_on = 1'b0; b3_on = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 256; k++) mem[i][k] = 8'h00;
            pos[i] = 0; pkts[i] = 0; drop_at[i] = -1; len[i] = 1;
        end
        b_pos = 0; b_on = 1'b0; b3_on = 1'b0;
        drive();
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000) begin
            bad++; $display("FAIL reset_gnt: got %b want 0000", gnt);
        end
        total++;
        if (pop !== 4'b0000) begin
            bad++; $display("FAIL reset_pop: got %b want 0000", pop);
        end
        total++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL reset_busy_err: got %b%b want 00", busy, err);
        end
        total++;
        if (ctl !== 1'b1 || data !== 8'h00) begin
            bad++; $display("FAIL reset_link: got %b/%h want 1/00", ctl, data);
        end
        total++;
        if (bgnt !== 4'b0000 || berr !== 1'b0 || bctl !== 1'b1) begin
            bad++; $display("FAIL reset_b: got %b %b %b want 0000 0 1", bgnt, berr, bctl);
        end
    endtask

    task automatic test_single();
        logic [7:0] pk [5] = '{8'h05, 8'h11, 8'h22, 8'h42, 8'h78};
        logic       ec [10] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
        logic [7:0] ed [10] = '{8'h00, 8'h00, 8'h05, 8'h11, 8'h22,
                                8'h42, 8'h78, 8'h00, 8'h00, 8'h00};
        logic       cc [10];
        logic [7:0] dd [10];
        logic [3:0] gg [10];
        int gcnt = 0;
        do_reset();
        for (int k = 0; k < 5; k++) mem[1][k] = pk[k];
        len[1] = 5; pkts[1] = 1;
        drive();
        for (int c = 0; c < 10; c++) begin
            run_cycle();
            cc[c] = s_ctl; dd[c] = s_data; gg[c] = s_gnt;
            if (s_gnt == 4'b0010) gcnt++;
        end
        for (int c = 0; c < 10; c++) begin
            total++;
            if (cc[c] !== ec[c] || dd[c] !== ed[c]) begin
                bad++;
                $display("FAIL single_link[%0d]: got %b/%h want %b/%h",
                         c, cc[c], dd[c], ec[c], ed[c]);
            end
        end
        total++;
        if (gg[1] !== 4'b0010) begin
            bad++; $display("FAIL single_gnt_latency: got %b want 0010", gg[1]);
        end
        total++;
        if (gcnt != 5) begin
            bad++; $display("FAIL single_gnt_cycles: got %0d want 5", gcnt);
        end
        total++;
        if (s_err !== 1'b0) begin
            bad++; $display("FAIL single_err: got %b want 0", s_err);
        end
    endtask

    task automatic test_contention();
        int order [4] = '{0, 2, 3, 0};
        logic [8:0] exp_q [$];
        logic [8:0] tr [$];
        int oh_bad = 0;
        int start = -1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) mem[i][k] = {1'b1, 3'(i), 4'(k)};
            len[i] = 4;
        end
        pkts[0] = 2; pkts[2] = 1; pkts[3] = 1;
        drive();
        foreach (order[p]) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back({(k == 0), 1'b1, 3'(order[p]), 4'(k)});
            exp_q.push_back(9'h100);
        end
        for (int c = 0; c < 30; c++) begin
            run_cycle();
            tr.push_back({s_ctl, s_data});
            if ($countones(s_pop) > 1) oh_bad++;
        end
        for (int j = 0; j < tr.size(); j++) begin
            if (start < 0 && tr[j][8] && tr[j][7:0] != 8'h00) start = j;
        end
        total++;
        if (start != 2) begin
            bad++; $display("FAIL cont_first_header: got %0d want 2", start);
            start = 2;
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            total++;
            if (tr[start + j] !== exp_q[j]) begin
                bad++;
                $display("FAIL cont_link[%0d]: got %h want %h", j, tr[start + j], exp_q[j]);
            end
        end
        total++;
        if (oh_bad != 0) begin
            bad++; $display("FAIL cont_pop_onehot: got %0d bad cycles want 0", oh_bad);
        end
    endtask

    task automatic test_long();
        logic [8:0] tr [$];
        int gcnt = 0;
        int ctl_bad = 0;
        int dat_bad = 0;
        do_reset();
        mem[0][0] = 8'hC4;
        for (int k = 1; k < 204; k++) mem[0][k] = 8'(k);
        len[0] = 204; pkts[0] = 1;
        drive();
        for (int c = 0; c < 212; c++) begin
            run_cycle();
            tr.push_back({s_ctl, s_data});
            if (s_gnt == 4'b0001) gcnt++;
        end
        total++;
        if (tr[2] !== {1'b1, 8'hC4}) begin
            bad++; $display("FAIL long_header: got %h want 1c4", tr[2]);
        end
        for (int j = 1; j < 204; j++) begin
            if (tr[2 + j][8] !== 1'b0) ctl_bad++;
            if (tr[2 + j][7:0] !== 8'(j)) dat_bad++;
        end
        total++;
        if (ctl_bad != 0) begin
            bad++; $display("FAIL long_ctl: got %0d bad want 0", ctl_bad);
        end
        total++;
        if (dat_bad != 0) begin
            bad++; $display("FAIL long_data: got %0d bad want 0", dat_bad);
        end
        total++;
        if (tr[206] !== 9'h100) begin
            bad++; $display("FAIL long_tail_idle: got %h want 100", tr[206]);
        end
        total++;
        if (gcnt != 204) begin
            bad++; $display("FAIL long_gnt_cycles: got %0d want 204", gcnt);
        end
        total++;
        if (s_err !== 1'b0) begin
            bad++; $display("FAIL long_err: got %b want 0", s_err);
        end
    endtask

    task automatic test_overrun();
        logic [8:0] bl [14];
        logic [3:0] bg [14];
        logic       be [14];
        int pcnt = 0;
        do_reset();
        b_on = 1'b1;
        drive();
        for (int c = 0; c < 14; c++) begin
            run_cycle();
            bl[c] = {s_bctl, s_bdata}; bg[c] = s_bgnt; be[c] = s_berr;
            if (c < 12 && s_bpop[2]) pcnt++;
            if (c == 3) begin
                b3_on = 1'b1;
                drive();
            end
        end
        total++;
        if (pcnt != 8) begin
            bad++; $display("FAIL ovr_pops: got %0d want 8", pcnt);
        end
        total++;
        if (bl[2] !== {1'b1, 8'h30}) begin
            bad++; $display("FAIL ovr_header: got %h want 130", bl[2]);
        end
        total++;
        if (bl[9] !== {1'b0, 8'h37}) begin
            bad++; $display("FAIL ovr_last: got %h want 037", bl[9]);
        end
        total++;
        if (bl[10] !== 9'h100) begin
            bad++; $display("FAIL ovr_idle: got %h want 100", bl[10]);
        end
        total++;
        if (be[8] !== 1'b0 || be[9] !== 1'b1) begin
            bad++; $display("FAIL ovr_err_edge: got %b%b want 01", be[8], be[9]);
        end
        total++;
        if (bg[9] !== 4'b0000 || bg[10] !== 4'b1000) begin
            bad++; $display("FAIL ovr_next_ptr3: got %b %b want 0000 1000", bg[9], bg[10]);
        end
    endtask

    task automatic test_abort();
        logic [8:0] ll [9];
        logic [3:0] gg [9];
        logic [3:0] pp [9];
        logic       ee [9];
        do_reset();
        for (int k = 0; k < 6; k++) mem[1][k] = 8'(8'h91 + k);
        for (int k = 0; k < 4; k++) mem[2][k] = 8'(8'hA1 + k);
        len[1] = 6; pkts[1] = 1; drop_at[1] = 3;
        len[2] = 4; pkts[2] = 1;
        drive();
        for (int c = 0; c < 9; c++) begin
            run_cycle();
            ll[c] = {s_ctl, s_data}; gg[c] = s_gnt; pp[c] = s_pop; ee[c] = s_err;
        end
        total++;
        if (gg[3] !== 4'b0010 || ll[4] !== {1'b0, 8'h93}) begin
            bad++; $display("FAIL abort_pre: got %b %h want 0010 093", gg[3], ll[4]);
        end
        total++;
        if (pp[4] !== 4'b0000 || ee[4] !== 1'b0) begin
            bad++; $display("FAIL abort_nopop: got %b %b want 0000 0", pp[4], ee[4]);
        end
        total++;
        if (ll[5] !== 9'h100) begin
            bad++; $display("FAIL abort_link_idle: got %h want 100", ll[5]);
        end
        total++;
        if (ee[5] !== 1'b1 || gg[5] !== 4'b0000) begin
            bad++; $display("FAIL abort_err_gnt: got %b %b want 1 0000", ee[5], gg[5]);
        end
        total++;
        if (gg[6] !== 4'b0100 || ll[7] !== {1'b1, 8'hA1}) begin
            bad++; $display("FAIL abort_next: got %b %h want 0100 1a1", gg[6], ll[7]);
        end
    endtask

    task automatic test_reset_mid();
        logic       ec [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
        logic [7:0] ed [8] = '{8'h00, 8'h00, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'h00};
        logic [8:0] ll [8];
        logic [3:0] gg [8];
        do_reset();
        for (int k = 0; k < 5; k++) mem[0][k] = 8'(8'hE1 + k);
        len[0] = 5; pkts[0] = 1;
        drive();
        repeat (3) run_cycle();
        total++;
        if (s_gnt !== 4'b0001) begin
            bad++; $display("FAIL rmid_pre_gnt: got %b want 0001", s_gnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (gnt !== 4'b0000 || pop !== 4'b0000 || busy !== 1'b0) begin
            bad++; $display("FAIL rmid_async: got %b %b %b want 0000 0000 0", gnt, pop, busy);
        end
        total++;
        if (ctl !== 1'b1 || data !== 8'h00) begin
            bad++; $display("FAIL rmid_link: got %b/%h want 1/00", ctl, data);
        end
        pos[0] = 0; pkts[0] = 1;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            ll[c] = {s_ctl, s_data}; gg[c] = s_gnt;
        end
        total++;
        if (gg[1] !== 4'b0001) begin
            bad++; $display("FAIL rmid_regrant: got %b want 0001", gg[1]);
        end
        for (int c = 0; c < 8; c++) begin
            total++;
            if (ll[c] !== {ec[c], ed[c]}) begin
                bad++;
                $display("FAIL rmid_link[%0d]: got %h want %b/%h", c, ll[c], ec[c], ed[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_long();
        test_overrun();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
